regfile_wport_arbiter: RTL and testbench
========================================

// Module: regfile_wport_arbiter
// PURPOSE
//  Shares the single register-file write port among NREQ writers (WB stage, load unit, CSR/tick unit)
//  with valid/ready handshakes and round-robin arbitration. Also sequences the file's interrupt
//  backup flag (be_o) and guarantees no write lands in the enter/restore cycles.
//  Sits between the pipeline writers and CustomRegfiles (drives we_i/waddr_i/wdata_i/be_i).
// PARAMETERS
//  NREQ        3   number of write requesters (2..8)
//  ADDR_WIDTH  5   register address width
//  DATA_WIDTH  32  register data width
// PORTS
//  clk          in   1              clock; all state on rising edge
//  rst          in   1              asynchronous, active-low reset
//  req_valid_i  in   NREQ           requester k has a write pending
//  req_addr_i   in   NREQ*ADDR_W    packed, slice k = requester k address
//  req_data_i   in   NREQ*DATA_W    packed, slice k = requester k data
//  req_ready_o  out  NREQ           one-hot grant; transfer when valid&ready same cycle
//  irq_i        in   1              interrupt entry strobe (1 cycle)
//  eret_i       in   1              interrupt return strobe (1 cycle)
//  we_o         out  1              regfile write enable (registered)
//  waddr_o      out  ADDR_WIDTH     regfile write address (registered)
//  wdata_o      out  DATA_WIDTH     regfile write data (registered)
//  be_o         out  1              backup/in-interrupt flag to regfile (registered)
//  ctx_busy_o   out  1              1 in ENTER/RESTORE: writers must hold
// BEHAVIOUR
//  Reset (rst=0, async): state=RUN, rr pointer=0, we_o=0, waddr_o=0, wdata_o=0, be_o=0,
//   req_ready_o=0, ctx_busy_o=0. Reset mid-transfer discards the in-flight write.
//  FSM: RUN -(irq_i)-> ENTER -(1 cyc)-> ISR -(eret_i)-> RESTORE -(1 cyc)-> RUN.
//   be_o=1 in ENTER and ISR; be_o=0 in RUN and RESTORE. ctx_busy_o=1 in ENTER, RESTORE.
//   eret_i in RUN/ENTER ignored; irq_i in ENTER/ISR/RESTORE ignored (no nesting).
//   irq_i and eret_i together in RUN: irq taken. Together in ISR: eret taken.
//  Grant (combinational, from valid + rr pointer): in RUN/ISR, at most one req_ready_o bit high,
//   for the first valid requester at or after rr pointer, wrapping NREQ-1 -> 0.
//   No grants in ENTER/RESTORE, nor in the cycle irq_i (RUN) or eret_i (ISR) is accepted.
//  On transfer of k: next cycle we_o=1, waddr_o/wdata_o = slice k; rr pointer <- (k+1) mod NREQ.
//   No transfer: we_o=0, waddr_o/wdata_o hold previous values.
//  Address 0: transfer accepted (ready given) but we_o stays 0 next cycle (write dropped).
//  Latency: valid -> we_o = 1 cycle when granted; throughput 1 write/cycle.
//  RESTORE cycle: we_o=0 and be_o falls, so the regfile's restore (be low, prev be high, no write) fires.
//  Requesters must hold valid/addr/data stable until ready; deasserting valid early is legal (no transfer).
// CONFIGURATION
//  REGFILE_ARB_PRIO0_EN defined: requester 0 always wins when valid (WB stage priority); remaining
//   requesters round-robin among themselves; rr pointer updated only on grants to k>=1.
//  Not defined: pure round-robin over all NREQ requesters as above.
// TESTING
//  Single req1 valid, addr=3 data=0xDEAD -> ready[1] same cycle; next cycle we_o=1 waddr_o=3 wdata_o=0xDEAD.
//  All 3 valid continuously from reset -> grants 0,1,2,0,1,... one per cycle (macro off);
//   macro on -> grants 0,0,0,... while req0 valid.
//  req0 addr=0 data=5 -> ready[0]=1, next cycle we_o=0.
//  irq_i pulse in RUN with req valid -> no grant that cycle; be_o=1 next two cycles with ctx_busy_o 1 then 0;
//   eret_i in ISR -> RESTORE cycle with be_o=0, we_o=0, ctx_busy_o=1; then RUN grants resume.
//  irq_i and eret_i together in RUN -> enter ENTER; eret_i while in RUN alone -> no state change.
//  rst low during ISR with we_o=1 pending -> all outputs 0 immediately, state RUN after release.

Source files
------------

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus the interrupt backup-flag sequencer.
// Optional build macro REGFILE_ARB_PRIO0_EN: requester 0 (WB stage) always wins, the rest round-robin.
module regfile_wport_arbiter #(
   parameter int NREQ       = 3,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid_i,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NREQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]            req_ready_o,
   input  logic                       irq_i,
   input  logic                       eret_i,
   output logic                       we_o,
   output logic [ADDR_WIDTH-1:0]      waddr_o,
   output logic [DATA_WIDTH-1:0]      wdata_o,
   output logic                       be_o,
   output logic                       ctx_busy_o,
   output logic [1:0]                 dbg_state_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_ENTER   = 2'd1,
      ST_ISR     = 2'd2,
      ST_RESTORE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         rr_q, rr_d;
   logic                  grant_en;
   logic                  gnt_any;
   logic [PW-1:0]         gnt_idx;
   logic [ADDR_WIDTH-1:0] addr_sel;
   logic [DATA_WIDTH-1:0] data_sel;

   // Handshake: requester k transfers in a cycle where req_valid_i[k] && req_ready_o[k];
   // ready never depends on the requester dropping valid, and valid/addr/data must hold until ready.

   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (irq_i) state_d = ST_ENTER;
            else       grant_en = 1'b1;
         end
         ST_ENTER:   state_d = ST_ISR;
         ST_ISR: begin
            if (eret_i) state_d = ST_RESTORE;
            else        grant_en = 1'b1;
         end
         ST_RESTORE: state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase
      // No grant may be visible while reset is held.
      if (!rst) grant_en = 1'b0;
   end

   always_comb begin
      int            cand;
      int            start;
      logic [PW-1:0] cand_idx;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      cand     = 0;
      start    = 0;
      cand_idx = '0;
`ifdef REGFILE_ARB_PRIO0_EN
      if (req_valid_i[0]) begin
         gnt_any = 1'b1;
      end else begin
         // Rotation covers requesters 1..NREQ-1 only; a pointer of 0 means "start at 1".
         start = (rr_q == '0) ? 1 : int'(rr_q);
         for (int i = 0; i < NREQ - 1; i++) begin
            cand = start + i;
            if (cand >= NREQ) cand = cand - (NREQ - 1);
            cand_idx = PW'(cand);
            if (!gnt_any && req_valid_i[cand_idx]) begin
               gnt_any = 1'b1;
               gnt_idx = cand_idx;
            end
         end
      end
`else
      start = int'(rr_q);
      for (int i = 0; i < NREQ; i++) begin
         cand = start + i;
         if (cand >= NREQ) cand = cand - NREQ;
         cand_idx = PW'(cand);
         if (!gnt_any && req_valid_i[cand_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = cand_idx;
         end
      end
`endif
      if (!grant_en) gnt_any = 1'b0;
   end

   always_comb begin
      req_ready_o = '0;
      if (gnt_any) req_ready_o[gnt_idx] = 1'b1;
      addr_sel = req_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      data_sel = req_data_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      rr_d     = rr_q;
`ifdef REGFILE_ARB_PRIO0_EN
      if (gnt_any && gnt_idx != '0)
`else
      if (gnt_any)
`endif
         rr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         rr_q    <= '0;
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
         be_o    <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         // Writes to register 0 are accepted from the requester but never reach the file.
         we_o    <= gnt_any && (addr_sel != '0);
         if (gnt_any) begin
            waddr_o <= addr_sel;
            wdata_o <= data_sel;
         end
         be_o    <= (state_d == ST_ENTER) || (state_d == ST_ISR);
      end
   end

   assign ctx_busy_o  = (state_q == ST_ENTER) || (state_q == ST_RESTORE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: handshake, round-robin order, addr-0 drop,
// irq/eret sequencing and asynchronous reset.
module tb_regfile_wport_arbiter;
   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;

   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_ENTER   = 2'd1;
   localparam logic [1:0] S_ISR     = 2'd2;
   localparam logic [1:0] S_RESTORE = 2'd3;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 irq;
   logic                 eret;
   logic                 we;
   logic [AW-1:0]        waddr;
   logic [DW-1:0]        wdata;
   logic                 be;
   logic                 ctx_busy;
   logic [1:0]           dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [AW-1:0] exp_q[$];

   regfile_wport_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_addr_i  (req_addr),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .irq_i       (irq),
      .eret_i      (eret),
      .we_o        (we),
      .waddr_o     (waddr),
      .wdata_o     (wdata),
      .be_o        (be),
      .ctx_busy_o  (ctx_busy),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[k*AW +: AW] = a;
      req_data[k*DW +: DW] = d;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      req_valid = '0;
      irq       = 1'b0;
      eret      = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      int exp_k;
      rst       = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      irq       = 1'b0;
      eret      = 1'b0;

      // reset values
      #3;
      check("rst_ready", req_ready, 3'b000);
      check("rst_we", we, 0);
      check("rst_waddr", waddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_be", be, 0);
      check("rst_busy", ctx_busy, 0);
      check("rst_state", dbg_state, S_RUN);
      tick();
      tick();
      rst = 1'b1;

      // single requester 1
      set_req(1, 5'd3, 32'hDEAD);
      req_valid = 3'b010;
      settle();
      check("t1_ready", req_ready, 3'b010);
      tick();
      req_valid = '0;
      check("t1_we", we, 1);
      check("t1_waddr", waddr, 3);
      check("t1_wdata", wdata, 32'hDEAD);
      tick();
      check("t1_we_clr", we, 0);
      check("t1_waddr_hold", waddr, 3);

      // all requesters continuously valid from reset
      do_reset();
      for (int k = 0; k < NREQ; k++) set_req(k, AW'(k + 1), DW'(32'h100 + k));
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
`ifdef REGFILE_ARB_PRIO0_EN
         exp_k = 0;
`else
         exp_k = c % NREQ;
`endif
         settle();
         check("rr_ready", req_ready, 64'(1) << exp_k);
         exp_q.push_back(AW'(exp_k + 1));
         tick();
         check("rr_we", we, 1);
         check("rr_waddr", waddr, exp_q.pop_front());
      end
      req_valid = '0;

      // write to register 0 is accepted but dropped
      do_reset();
      set_req(0, 5'd0, 32'd5);
      req_valid = 3'b001;
      settle();
      check("a0_ready", req_ready, 3'b001);
      tick();
      req_valid = '0;
      check("a0_we", we, 0);

      // interrupt entry / return
      do_reset();
      set_req(1, 5'd4, 32'h44);
      req_valid = 3'b010;
      irq       = 1'b1;
      settle();
      check("irq_ready", req_ready, 3'b000);
      tick();
      irq = 1'b0;
      settle();
      check("enter_state", dbg_state, S_ENTER);
      check("enter_be", be, 1);
      check("enter_busy", ctx_busy, 1);
      check("enter_ready", req_ready, 3'b000);
      check("enter_we", we, 0);
      tick();
      check("isr_state", dbg_state, S_ISR);
      check("isr_be", be, 1);
      check("isr_busy", ctx_busy, 0);
      check("isr_ready", req_ready, 3'b010);
      tick();
      eret = 1'b1;
      settle();
      check("isr_we", we, 1);
      check("isr_waddr", waddr, 4);
      check("eret_ready", req_ready, 3'b000);
      tick();
      eret = 1'b0;
      settle();
      check("rest_state", dbg_state, S_RESTORE);
      check("rest_be", be, 0);
      check("rest_we", we, 0);
      check("rest_busy", ctx_busy, 1);
      check("rest_ready", req_ready, 3'b000);
      tick();
      check("resume_state", dbg_state, S_RUN);
      check("resume_ready", req_ready, 3'b010);
      req_valid = '0;
      tick();

      // irq and eret together: irq wins in RUN, eret wins in ISR; lone eret in RUN ignored
      irq  = 1'b1;
      eret = 1'b1;
      tick();
      irq  = 1'b0;
      eret = 1'b0;
      check("both_run_state", dbg_state, S_ENTER);
      tick();
      irq  = 1'b1;
      eret = 1'b1;
      tick();
      irq  = 1'b0;
      eret = 1'b0;
      check("both_isr_state", dbg_state, S_RESTORE);
      tick();
      eret = 1'b1;
      tick();
      eret = 1'b0;
      check("eret_run_state", dbg_state, S_RUN);
      check("eret_run_be", be, 0);

      // asynchronous reset during ISR with a write pending
      do_reset();
      irq = 1'b1;
      tick();
      irq = 1'b0;
      tick();
      set_req(1, 5'd7, 32'h77);
      req_valid = 3'b010;
      settle();
      check("pre_rst_ready", req_ready, 3'b010);
      tick();
      check("pre_rst_we", we, 1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_we", we, 0);
      check("mid_rst_waddr", waddr, 0);
      check("mid_rst_wdata", wdata, 0);
      check("mid_rst_be", be, 0);
      check("mid_rst_ready", req_ready, 3'b000);
      check("mid_rst_busy", ctx_busy, 0);
      req_valid = '0;
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_state", dbg_state, S_RUN);
      check("post_rst_we", we, 0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
